// File: rtl/dmem_bank_ctrl.sv
// dmem_bank_ctrl: data-memory controller for the pipelined CPU.
// Provides a valid/ready request port and a LATENCY-cycle response strobe.
// It supports byte-lane writes and reports misaligned or out-of-range accesses.
// Writes commit, and read data is captured, at the acceptance edge, so a
// read that directly follows a write to the same word sees the new data.
// The DMEM_PERF_EN macro enables the read/write performance counters.
// In the default build the macro is undefined and both counter outputs are 0.
module dmem_bank_ctrl #(
  parameter int unsigned             DATA_W    = 32,
  parameter int unsigned             DEPTH     = 2048,
  parameter int unsigned             ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]       BASE_ADDR = '0,
  parameter int unsigned             LATENCY   = 1
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic                req_valid,
  input  logic                req_we,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                req_ready,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy,
  output logic [31:0]         perf_rd_cnt,
  output logic [31:0]         perf_wr_cnt
);

  localparam int unsigned NB     = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(NB);
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               ready_c;
  logic               busy_c;
  logic               rsp_valid_c;
  logic               accept_c;

  logic [ADDR_W-1:0]  off;
  logic [ADDR_W-1:0]  idx_full;
  logic [IDX_W-1:0]   idx;
  logic               dec_err;

  logic [DATA_W-1:0]  mem [DEPTH];

  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               err_q, err_d;

  // Address decode: byte offset from the base, word index, and error flags.
  always_comb begin
    off      = req_addr - BASE_ADDR;
    idx_full = off >> OFF_W;
    idx      = idx_full[IDX_W-1:0];
    dec_err  = (req_addr < BASE_ADDR) ||
               (off[OFF_W-1:0] != '0) ||
               (idx_full >= ADDR_W'(DEPTH));
  end

  // State and latency-counter register.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic, handshake outputs and the acceptance strobe.
  // Reset is folded into the acceptance strobe so that a request presented
  // on a reset edge never commits to the array or bumps a counter.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ready_c     = 1'b0;
    busy_c      = 1'b0;
    rsp_valid_c = 1'b0;
    accept_c    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ready_c  = 1'b1;
        accept_c = req_valid && !reset;
        if (accept_c) begin
          state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      S_WAIT: begin
        busy_c = 1'b1;
        if (cnt_q == '0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        ready_c     = 1'b1;
        busy_c      = 1'b1;
        rsp_valid_c = 1'b1;
        accept_c    = req_valid && !reset;
        if (accept_c) begin
          state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
          cnt_d   = CNT_INIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Byte-lane array write at the acceptance edge; the array has no reset.
  always_ff @(posedge clk_in) begin
    if (accept_c && req_we && !dec_err) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (req_be[i]) begin
          mem[idx][i*8 +: 8] <= req_wdata[i*8 +: 8];
        end
      end
    end
  end

  // Response payload for the accepted request; writes and errors return zero.
  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept_c) begin
      err_d   = dec_err;
      rdata_d = (!req_we && !dec_err) ? mem[idx] : '0;
    end
  end

  // Response payload register, captured at acceptance.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = ready_c;
  assign rsp_valid = rsp_valid_c;
  assign busy      = busy_c;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

`ifdef DMEM_PERF_EN
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  // Accepted-request counters, including erroneous accesses; wrap naturally.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (accept_c) begin
      if (req_we) begin
        wr_cnt_d = wr_cnt_q + 32'd1;
      end else begin
        rd_cnt_d = rd_cnt_q + 32'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign perf_rd_cnt = rd_cnt_q;
  assign perf_wr_cnt = wr_cnt_q;
`else
  assign perf_rd_cnt = '0;
  assign perf_wr_cnt = '0;
`endif

endmodule

// File: tb/tb_dmem_bank_ctrl.sv
// Testbench for dmem_bank_ctrl.
// Three instances are used: LATENCY 1, 3 and 4 (index 0, 1 and 2).
// A table of directed vectors runs on the LATENCY=1 instance.
// Hand-written sequences cover back-to-back handshakes and reset during WAIT.
// Random traffic is checked against a word-array reference model.
module tb_dmem_bank_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [3];
  logic        valid [3];
  logic        we    [3];
  logic [3:0]  be    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic        ready [3];
  logic        rv    [3];
  logic [31:0] rdata [3];
  logic        err   [3];
  logic        busy  [3];
  logic [31:0] prd   [3];
  logic [31:0] pwr   [3];

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: one word array per instance plus accepted-request counts.
  logic [31:0] mdl [3][2048];
  int          rd_cnt [3];
  int          wr_cnt [3];

  typedef struct {
    bit          w;
    logic [3:0]  b;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t tbl [15];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_bank_ctrl #(
      .DATA_W   (32),
      .DEPTH    (2048),
      .ADDR_W   (32),
      .BASE_ADDR(32'h0),
      .LATENCY  ((g == 0) ? 1 : ((g == 1) ? 3 : 4))
    ) u_dut (
      .clk_in     (clk),
      .reset      (rst[g]),
      .req_valid  (valid[g]),
      .req_we     (we[g]),
      .req_be     (be[g]),
      .req_addr   (addr[g]),
      .req_wdata  (wdata[g]),
      .req_ready  (ready[g]),
      .rsp_valid  (rv[g]),
      .rsp_rdata  (rdata[g]),
      .rsp_err    (err[g]),
      .busy       (busy[g]),
      .perf_rd_cnt(prd[g]),
      .perf_wr_cnt(pwr[g])
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Apply one request to the model: 4-byte words, base 0, 2048 words.
  task automatic model_apply(input int k, input bit w, input logic [3:0] b,
                             input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] er, output bit ee);
    ee = (a % 4 != 0) || ((a / 4) >= 2048);
    er = '0;
    if (w) wr_cnt[k]++;
    else   rd_cnt[k]++;
    if (!ee) begin
      if (w) begin
        for (int j = 0; j < 4; j++)
          if (b[j]) mdl[k][a / 4][j*8 +: 8] = d[j*8 +: 8];
      end else begin
        er = mdl[k][a / 4];
      end
    end
  endtask

  // Present a request and hold it until accepted; returns #1 after the edge.
  task automatic issue(input int k, input bit w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d, output bit ok);
    int n = 0;
    valid[k] = 1'b1; we[k] = w; be[k] = b; addr[k] = a; wdata[k] = d;
    while (ready[k] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = (n < 50);
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout: inst %0d got ready=%b, expected 1", k, ready[k]);
      valid[k] = 1'b0;
      return;
    end
    @(posedge clk);
    #1 valid[k] = 1'b0;
  endtask

  // Wait for the response strobe and check its latency and payload.
  task automatic wait_rsp(input int k, input logic [31:0] er, input bit ee, input string name);
    int  c = 0;
    bit  seen = 1'b0;
    while (!seen && c < lat_of(k) + 6) begin
      @(negedge clk);
      c++;
      if (rv[k] === 1'b1) seen = 1'b1;
    end
    chk({name, "_lat"}, seen ? 32'(c) : 32'hFFFF_FFFF, 32'(lat_of(k)));
    if (seen) begin
      chk({name, "_rdata"}, rdata[k], er);
      chk({name, "_err"}, {31'd0, err[k]}, {31'd0, ee});
    end
  endtask

  task automatic run(input int k, input bit w, input logic [3:0] b, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] er, input bit ee, input string name);
    bit ok;
    issue(k, w, b, a, d, ok);
    if (ok) wait_rsp(k, er, ee, name);
  endtask

  task automatic chk_perf(input int k, input string name);
`ifdef DMEM_PERF_EN
    chk({name, "_rd"}, prd[k], 32'(rd_cnt[k]));
    chk({name, "_wr"}, pwr[k], 32'(wr_cnt[k]));
`else
    chk({name, "_rd"}, prd[k], 32'd0);
    chk({name, "_wr"}, pwr[k], 32'd0);
`endif
  endtask

  initial begin
    logic [31:0] er, er0, er1;
    bit          ee, ee0, ee1;
    bit          ok;
    int          hits;

    tbl[0]  = '{1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    tbl[1]  = '{1'b0, 4'hF, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    tbl[2]  = '{1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344, 32'h0000_0000, 1'b0};
    tbl[3]  = '{1'b1, 4'h5, 32'h0000_0020, 32'hAABB_CCDD, 32'h0000_0000, 1'b0};
    tbl[4]  = '{1'b0, 4'h0, 32'h0000_0020, 32'h0000_0000, 32'h11BB_33DD, 1'b0};
    tbl[5]  = '{1'b1, 4'hF, 32'h0000_0000, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
    tbl[6]  = '{1'b0, 4'h0, 32'h0000_0022, 32'h0000_0000, 32'h0000_0000, 1'b1};
    tbl[7]  = '{1'b1, 4'hF, 32'h0000_2000, 32'h1234_5678, 32'h0000_0000, 1'b1};
    tbl[8]  = '{1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
    tbl[9]  = '{1'b1, 4'h0, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    tbl[10] = '{1'b0, 4'h0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    tbl[11] = '{1'b1, 4'hF, 32'h0000_1FFC, 32'h0BAD_CAFE, 32'h0000_0000, 1'b0};
    tbl[12] = '{1'b0, 4'h0, 32'h0000_1FFC, 32'h0000_0000, 32'h0BAD_CAFE, 1'b0};
    tbl[13] = '{1'b0, 4'h0, 32'h0000_2001, 32'h0000_0000, 32'h0000_0000, 1'b1};
    tbl[14] = '{1'b1, 4'hF, 32'hFFFF_FFFC, 32'h0000_0001, 32'h0000_0000, 1'b1};

    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; valid[k] = 1'b0; we[k] = 1'b0; be[k] = '0;
      addr[k] = '0; wdata[k] = '0; rd_cnt[k] = 0; wr_cnt[k] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;

    // Reset state of every instance.
    for (int k = 0; k < 3; k++) begin
      chk("rst_ready", {31'd0, ready[k]}, 32'd1);
      chk("rst_rsp_valid", {31'd0, rv[k]}, 32'd0);
      chk("rst_busy", {31'd0, busy[k]}, 32'd0);
      chk("rst_rdata", rdata[k], 32'd0);
      chk("rst_err", {31'd0, err[k]}, 32'd0);
      chk_perf(k, "rst_perf");
    end

    // Directed vectors, LATENCY=1.
    for (int i = 0; i < 15; i++) begin
      model_apply(0, tbl[i].w, tbl[i].b, tbl[i].a, tbl[i].d, er, ee);
      run(0, tbl[i].w, tbl[i].b, tbl[i].a, tbl[i].d, tbl[i].exp_rdata, tbl[i].exp_err,
          $sformatf("tbl%0d", i));
    end

    // LATENCY=3: back-to-back reads with req_valid held across both.
    model_apply(1, 1'b1, 4'hF, 32'h0, 32'h0102_0304, er, ee);
    run(1, 1'b1, 4'hF, 32'h0, 32'h0102_0304, 32'h0, 1'b0, "l3_w0");
    model_apply(1, 1'b1, 4'hF, 32'h4, 32'hA0B0_C0D0, er, ee);
    run(1, 1'b1, 4'hF, 32'h4, 32'hA0B0_C0D0, 32'h0, 1'b0, "l3_w4");
    model_apply(1, 1'b0, 4'h0, 32'h0, 32'h0, er0, ee0);
    model_apply(1, 1'b0, 4'h0, 32'h4, 32'h0, er1, ee1);
    issue(1, 1'b0, 4'h0, 32'h0, 32'h0, ok);
    valid[1] = 1'b1; addr[1] = 32'h4;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      chk($sformatf("b2b_rv_c%0d", n), {31'd0, rv[1]}, {31'd0, (n == 3 || n == 6)});
      chk($sformatf("b2b_ready_c%0d", n), {31'd0, ready[1]}, {31'd0, (n == 3 || n == 6 || n == 7)});
      chk($sformatf("b2b_busy_c%0d", n), {31'd0, busy[1]}, {31'd0, (n <= 6)});
      if (n == 3) chk("b2b_rdata0", rdata[1], er0);
      if (n == 6) chk("b2b_rdata4", rdata[1], er1);
      if (n == 3) begin
        @(posedge clk);
        #1 valid[1] = 1'b0;
      end
    end

    // LATENCY=4: reset while the write response is pending.
    model_apply(2, 1'b1, 4'hF, 32'h8, 32'h5A5A_5A5A, er, ee);
    issue(2, 1'b1, 4'hF, 32'h8, 32'h5A5A_5A5A, ok);
    @(negedge clk);
    chk("wait_busy", {31'd0, busy[2]}, 32'd1);
    chk("wait_ready", {31'd0, ready[2]}, 32'd0);
    rst[2] = 1'b1;
    @(negedge clk);
    rst[2] = 1'b0;
    rd_cnt[2] = 0;
    wr_cnt[2] = 0;
    chk("postrst_ready", {31'd0, ready[2]}, 32'd1);
    chk("postrst_busy", {31'd0, busy[2]}, 32'd0);
    hits = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (rv[2] === 1'b1) hits++;
    end
    chk("rst_dropped_rsp", 32'(hits), 32'd0);
    model_apply(2, 1'b0, 4'h0, 32'h8, 32'h0, er, ee);
    run(2, 1'b0, 4'h0, 32'h8, 32'h0, er, ee, "rst_persist");
    chk_perf(2, "rst_perf");

    // Random traffic on a 16-word window, checked against the model.
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 16; w++) begin
        logic [31:0] d = $urandom;
        model_apply(k, 1'b1, 4'hF, 32'h400 + 32'(4 * w), d, er, ee);
        run(k, 1'b1, 4'hF, 32'h400 + 32'(4 * w), d, er, ee, "rnd_fill");
      end
      for (int t = 0; t < 120; t++) begin
        int          sel = $urandom_range(0, 9);
        int          w   = $urandom_range(0, 15);
        bit          rw  = 1'($urandom);
        logic [3:0]  rb  = 4'($urandom);
        logic [31:0] rd  = $urandom;
        logic [31:0] ra;
        if (sel == 0)      ra = 32'h400 + 32'(4 * w) + 32'($urandom_range(1, 3));
        else if (sel == 1) ra = 32'h2000 + 32'(4 * w);
        else               ra = 32'h400 + 32'(4 * w);
        model_apply(k, rw, rb, ra, rd, er, ee);
        run(k, rw, rb, ra, rd, er, ee, $sformatf("rnd%0d_%0d", k, t));
      end
      chk_perf(k, "end_perf");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
